lcd_bus_ctrl: RTL
=================

// Module: lcd_bus_ctrl
// PURPOSE
// - HD44780-compatible 8-bit LCD bus timing engine; downstream of the LCD init/text sequencer.
// - Takes one byte per request (data + RS) via a start/done handshake.
// - Generates setup, enable-pulse, hold and execution-wait timing on the LCD pins.
// - Signals completion, so the sequencer only supplies bytes and never counts bus cycles.
// PARAMETERS
// - T_SETUP      default 4       cycles RS/RW/data stable before EN rises (>=1)
// - T_EN_HIGH    default 16      cycles EN held high (>=1)
// - T_HOLD       default 4       cycles data/RS held after EN falls (>=1)
// - T_EXEC       default 2048    post-write wait, normal commands/data (~40us @50MHz)
// - T_EXEC_LONG  default 82000   post-write wait when i_rs=0 and i_data is 8'h01 or 8'h02
// - POLL_MAX     default 1024    busy-flag poll iterations before abort (poll build only)
// PORTS
// - i_clk          in     1  system clock
// - i_rst_n        in     1  asynchronous active-low reset
// - i_data         in     8  byte to write
// - i_rs           in     1  0=instruction, 1=data
// - i_start        in     1  request; level, held high by sequencer until it sees o_done
// - o_done         out    1  one-cycle pulse, transfer complete
// - o_busy         out    1  high from accept until the o_done cycle, inclusive
// - o_err          out    1  one-cycle pulse with o_done on poll timeout (0 when poll compiled out)
// - io_lcd_data    inout  8  LCD DB[7:0]
// - o_lcd_rw       out    1  LCD R/W (0=write)
// - o_lcd_en       out    1  LCD E
// - o_lcd_rs       out    1  LCD RS
// BEHAVIOUR
// - Reset value, all outputs: o_done=0, o_busy=0, o_err=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0.
// - Reset value, bus: io_lcd_data driven 8'h00.
// - Reset mid-transfer aborts immediately to IDLE; EN never left high.
// - FSM states: IDLE, SETUP, EN_HI, HOLD, EXEC, DONE, RELEASE.
// - IDLE: i_start=1 -> latch i_data/i_rs into the bus regs (rw=0), set o_busy, go to SETUP.
// - i_data and i_rs are ignored after accept.
// - SETUP: T_SETUP cycles with en=0, then EN_HI.
// - EN_HI: T_EN_HIGH cycles with en=1, then HOLD.
// - HOLD: T_HOLD cycles with en=0, then EXEC.
// - EXEC: T_EXEC cycles, or T_EXEC_LONG if the latched rs=0 and byte is 8'h01/8'h02; then DONE.
// - DONE: o_done=1 for exactly one cycle, then RELEASE.
// - Latency: o_done is high exactly N cycles after the accept edge.
// - N = 1+T_SETUP+T_EN_HIGH+T_HOLD+T_EXEC(sel).
// - RELEASE: wait for i_start=0, then IDLE. Stops a still-high start from re-sending the byte.
// - Start deassertion before done has no effect; the transfer always completes.
// - Delay counter: single down-counter of width $clog2(max(T_EXEC_LONG, T_EN_HIGH)+1).
// - Delay counter: reloaded on each state entry; no wrap.
// - Bus pins are registered outputs and glitch-free; data/RS change only in IDLE accept.
// CONFIGURATION
// - Macro LCD_BUSY_POLL_EN; behaviour when defined:
//   - EXEC is replaced by polling: bus released (tri-state), rs=0, rw=1.
//   - Each poll runs SETUP -> EN_HI -> HOLD using the same T_* timings.
//   - BF = io_lcd_data[7] is sampled on the last EN_HI cycle.
//   - BF=1 -> repeat poll. BF=0 -> rw=0, bus re-driven, then DONE.
//   - After POLL_MAX polls with BF=1 -> DONE with o_err=1.
// - When LCD_BUSY_POLL_EN is not defined:
//   - Fixed EXEC wait; io_lcd_data always driven; o_lcd_rw tied 0; o_err tied 0.
// TESTING
// - Params T_SETUP=2, T_EN_HIGH=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20 are used in all tests.
// - Write 9'h148 ('H'), start held -> rs=1, data=8'h48 stable; EN high exactly 3 cycles.
// - Same write, continued -> o_done pulse at cycle 13, o_busy=0 the cycle after.
// - Command 8'h01, rs=0 -> o_done at cycle 28, EN pulse 3 cycles.
// - Hold i_start high 10 cycles past o_done -> exactly one EN pulse; re-raise start -> second transfer.
// - Assert i_rst_n=0 during EN_HI -> o_lcd_en=0 and o_busy=0 asynchronously.
// - After reset release, the next start is accepted normally.
// - LCD_BUSY_POLL_EN, model BF=1 for 2 polls then 0 -> three rw=1 EN pulses, then o_done with o_err=0.
// - LCD_BUSY_POLL_EN, BF stuck 1, POLL_MAX=4 -> four polls, then o_done and o_err=1 together.

Source files
------------

// File: rtl/lcd_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_bus_ctrl
//
// Bus timing engine for an HD44780-compatible LCD in 8-bit mode. It sits
// downstream of the init/text sequencer. The sequencer supplies one byte
// (data + RS) per request. This block drives the LCD pins through setup,
// enable pulse, hold and the controller's execution time, then reports
// completion. The sequencer never has to count bus cycles.
//
// Handshake
//   The sequencer raises i_start and holds it high. The byte is latched on
//   the first clock edge where i_start is seen in IDLE (the accept edge).
//   o_busy goes high on that edge. o_done pulses for one cycle when the
//   transfer is complete. The engine then waits for i_start to drop before
//   it will accept another byte, so a start held high never re-sends.
//
// Ports
//   i_clk        in     1  system clock
//   i_rst_n      in     1  asynchronous active-low reset
//   i_data       in     8  byte to write
//   i_rs         in     1  0 = instruction, 1 = data
//   i_start      in     1  request level, held until o_done is seen
//   o_done       out    1  one-cycle completion pulse
//   o_busy       out    1  high from the accept edge through the o_done cycle
//   o_err        out    1  busy-flag poll timeout, pulses with o_done
//   io_lcd_data  inout  8  LCD DB[7:0]
//   o_lcd_rw     out    1  LCD R/W (0 = write)
//   o_lcd_en     out    1  LCD E
//   o_lcd_rs     out    1  LCD RS
//
// Configuration
//   LCD_BUSY_POLL_EN  When defined, the fixed post-write wait is replaced by
//                     reading the busy flag. Each read uses the same
//                     SETUP/EN_HI/HOLD timing, with the bus released and
//                     rw=1. If the flag stays set for POLL_MAX reads, the
//                     transfer completes with o_err.
//                     When undefined, the bus is always driven, o_lcd_rw is
//                     tied to 0 and o_err is tied to 0.
//
// Cycle budget (fixed-wait build). The accept cycle is cycle 0. SETUP,
// EN_HI, HOLD and EXEC then follow back to back, and o_done is high in cycle
//   1 + T_SETUP + T_EN_HIGH + T_HOLD + T_EXEC(sel)
// counted from that accept cycle.
// ---------------------------------------------------------------------------
module lcd_bus_ctrl #(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_EN_HIGH   = 16,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2048,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned POLL_MAX    = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_rs,
  input  logic       i_start,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_err,
  inout  wire  [7:0] io_lcd_data,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_rs
);

  // -------------------------------------------------------------------------
  // Delay counter sizing. A single down-counter covers every state. It is
  // sized for the longest wait, so all shorter loads fit without wrap.
  // -------------------------------------------------------------------------
  localparam int unsigned CNT_MAX = (T_EXEC_LONG > T_EN_HIGH) ? T_EXEC_LONG : T_EN_HIGH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Each state runs for T cycles: the counter is loaded with T-1 on entry
  // and the state exits on the cycle in which the counter reads zero.
  localparam cnt_t LD_SETUP   = cnt_t'(T_SETUP - 1);
  localparam cnt_t LD_EN_HIGH = cnt_t'(T_EN_HIGH - 1);
  localparam cnt_t LD_HOLD    = cnt_t'(T_HOLD - 1);

  // Reject parameter sets that would underflow a load value or not fit
  // the counter.
  if (T_SETUP < 1 || T_EN_HIGH < 1 || T_HOLD < 1 || T_EXEC < 1 ||
      POLL_MAX < 1 || T_SETUP > CNT_MAX || T_HOLD > CNT_MAX ||
      T_EXEC > CNT_MAX) begin : g_bad_params
    $error("lcd_bus_ctrl: illegal timing parameters");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EN_HI   = 3'd2,
    HOLD    = 3'd3,
    EXEC    = 3'd4,
    DONE    = 3'd5,
    RELEASE = 3'd6
  } state_t;

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   accept;

  // Bus holding registers. They are loaded only on the accept edge.
  logic [7:0] data_q;
  logic       rs_q;

  // Registered status and strobe outputs. Each one is decoded from the
  // next state, so it changes on the same edge as the state register.
  logic en_q;
  logic done_q;
  logic busy_q;

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned PC_W = $clog2(POLL_MAX + 1);
  typedef logic [PC_W-1:0] pcnt_t;
  localparam pcnt_t POLL_LAST = pcnt_t'(POLL_MAX - 1);

  logic  polling_q, polling_d;   // set while SETUP/EN_HI/HOLD are a flag read
  pcnt_t poll_cnt_q, poll_cnt_d; // completed reads that returned BF=1
  logic  bf_q;                   // busy flag from the most recent read
  logic  err_d, err_q;
  logic  rw_q;
  logic  oe_q;                   // 1 = this block drives io_lcd_data
  logic  rs_pin_q;               // RS forced low while reading the flag
`else
  localparam cnt_t LD_EXEC      = cnt_t'(T_EXEC - 1);
  localparam cnt_t LD_EXEC_LONG = cnt_t'(T_EXEC_LONG - 1);

  // Clear display (0x01) and return home (0x02) take far longer to execute
  // than any other instruction.
  logic long_cmd;
  assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. Otherwise any
  // path through the case that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    polling_d  = polling_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = LD_SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EN_HI;
          cnt_d   = LD_EN_HIGH;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      EN_HI: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
`ifdef LCD_BUSY_POLL_EN
          if (!polling_q) begin
            // Write cycle finished: start the first busy-flag read.
            polling_d  = 1'b1;
            poll_cnt_d = '0;
            state_d    = SETUP;
            cnt_d      = LD_SETUP;
          end else if (!bf_q) begin
            polling_d = 1'b0;
            state_d   = DONE;
          end else if (poll_cnt_q == POLL_LAST) begin
            polling_d = 1'b0;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            poll_cnt_d = poll_cnt_q + pcnt_t'(1);
            state_d    = SETUP;
            cnt_d      = LD_SETUP;
          end
`else
          state_d = EXEC;
          cnt_d   = long_cmd ? LD_EXEC_LONG : LD_EXEC;
`endif
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      DONE: state_d = RELEASE;

      // Hold here until the sequencer drops start. This keeps a start that
      // is still high from re-sending the same byte.
      RELEASE: begin
        if (!i_start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counter and pin registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples values from before the edge, whatever order the blocks
  // evaluate in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= i_data;
        rs_q   <= i_rs;
      end
      en_q   <= (state_d == EN_HI);
      done_q <= (state_d == DONE);
      busy_q <= !(state_d inside {IDLE, RELEASE});
    end
  end

`ifdef LCD_BUSY_POLL_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      polling_q  <= 1'b0;
      poll_cnt_q <= '0;
      bf_q       <= 1'b0;
      err_q      <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b1;
      rs_pin_q   <= 1'b0;
    end else begin
      polling_q  <= polling_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      // Sample BF in the last EN-high cycle, while the LCD is driving it.
      if (state_q == EN_HI && cnt_q == '0 && polling_q) begin
        bf_q <= io_lcd_data[7];
      end
      rw_q     <= polling_d;
      oe_q     <= !polling_d;
      rs_pin_q <= polling_d ? 1'b0 : (accept ? i_rs : rs_q);
    end
  end

  assign io_lcd_data = oe_q ? data_q : 8'hzz;
  assign o_lcd_rw    = rw_q;
  assign o_lcd_rs    = rs_pin_q;
  assign o_err       = err_q;
`else
  assign io_lcd_data = data_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_rs    = rs_q;
  assign o_err       = 1'b0;
`endif

  assign o_lcd_en = en_q;
  assign o_done   = done_q;
  assign o_busy   = busy_q;

endmodule
